// File: rtl/swipt_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : swipt_frame_sequencer
// Brief    : Transmit-side frame controller for the SWIPT duty-cycle
//            modulator. Sends preamble, MSB-first data, optional even parity
//            (compile with SWIPT_SEQ_PARITY_EN) and a guard interval.
// Revision : 1.0 - initial release
// ============================================================================
module swipt_frame_sequencer #(
    parameter int DATA_W        = 8,
    parameter int BIT_CYCLES    = 1000,
    parameter int PREAMBLE_BITS = 4,
    parameter int GUARD_CYCLES  = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swipt_alive,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic [1:0]        dp_program,
    output logic              write,
    output logic              read,
    output logic              data,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int c_TMR_MAX = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX);
    localparam int c_CNT_MAX = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_TMR_W-1:0] c_BIT_RELOAD   = c_TMR_W'(BIT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_GUARD_RELOAD = c_TMR_W'(GUARD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE      = c_TMR_W'(1);
    localparam logic [c_CNT_W-1:0] c_PRE_LOAD     = c_CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LOAD    = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_PREAMBLE = 3'd1;
    localparam logic [2:0] c_ST_DATA     = 3'd2;
    localparam logic [2:0] c_ST_GUARD    = 3'd4;
`ifdef SWIPT_SEQ_PARITY_EN
    localparam logic [2:0] c_ST_PARITY   = 3'd3;
`endif

    logic [2:0]        r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_shift;
`ifdef SWIPT_SEQ_PARITY_EN
    logic              r_parity;
`endif
    logic [1:0]        r_program;
    logic              r_write;
    logic              r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;

    logic              w_expire;
    logic [DATA_W-1:0] w_shift_next;

    assign w_expire     = (r_timer == '0);
    assign w_shift_next = r_shift << 1;

    assign req_ready  = (r_state == c_ST_IDLE) && swipt_alive;
    assign dp_program = r_program;
    assign write      = r_write;
    assign read       = 1'b0;
    assign data       = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_timer   <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
`ifdef SWIPT_SEQ_PARITY_EN
            r_parity  <= 1'b0;
`endif
            r_program <= 2'b00;
            r_write   <= 1'b0;
            r_data    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            // Link loss wins over any timer expiry, including the guard's.
            if ((r_state != c_ST_IDLE) && !swipt_alive) begin
                r_state   <= c_ST_IDLE;
                r_timer   <= '0;
                r_cnt     <= '0;
                r_program <= 2'b00;
                r_write   <= 1'b0;
                r_data    <= 1'b0;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (req_valid && swipt_alive) begin
                            r_shift   <= req_data;
`ifdef SWIPT_SEQ_PARITY_EN
                            r_parity  <= ^req_data;
`endif
                            r_timer   <= c_BIT_RELOAD;
                            r_cnt     <= c_PRE_LOAD;
                            r_state   <= c_ST_PREAMBLE;
                            r_program <= 2'b11;
                            r_write   <= 1'b1;
                            r_data    <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                    c_ST_PREAMBLE: begin
                        if (w_expire) begin
                            r_timer <= c_BIT_RELOAD;
                            if (r_cnt == '0) begin
                                r_state <= c_ST_DATA;
                                r_cnt   <= c_DATA_LOAD;
                                r_data  <= r_shift[DATA_W-1];
                            end else begin
                                r_cnt  <= r_cnt - c_CNT_ONE;
                                r_data <= ~r_data;
                            end
                        end else begin
                            r_timer <= r_timer - c_TMR_ONE;
                        end
                    end
                    c_ST_DATA: begin
                        if (w_expire) begin
                            r_shift <= w_shift_next;
                            if (r_cnt == '0) begin
`ifdef SWIPT_SEQ_PARITY_EN
                                r_state   <= c_ST_PARITY;
                                r_timer   <= c_BIT_RELOAD;
                                r_data    <= r_parity;
`else
                                r_state   <= c_ST_GUARD;
                                r_timer   <= c_GUARD_RELOAD;
                                r_program <= 2'b00;
                                r_write   <= 1'b0;
                                r_data    <= 1'b0;
`endif
                            end else begin
                                r_timer <= c_BIT_RELOAD;
                                r_cnt   <= r_cnt - c_CNT_ONE;
                                r_data  <= w_shift_next[DATA_W-1];
                            end
                        end else begin
                            r_timer <= r_timer - c_TMR_ONE;
                        end
                    end
`ifdef SWIPT_SEQ_PARITY_EN
                    c_ST_PARITY: begin
                        if (w_expire) begin
                            r_state   <= c_ST_GUARD;
                            r_timer   <= c_GUARD_RELOAD;
                            r_program <= 2'b00;
                            r_write   <= 1'b0;
                            r_data    <= 1'b0;
                        end else begin
                            r_timer <= r_timer - c_TMR_ONE;
                        end
                    end
`endif
                    c_ST_GUARD: begin
                        if (w_expire) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_timer <= r_timer - c_TMR_ONE;
                        end
                    end
                    default: begin
                        r_state   <= c_ST_IDLE;
                        r_program <= 2'b00;
                        r_write   <= 1'b0;
                        r_data    <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/swipt_frame_sequencer.md
# swipt_frame_sequencer

- Transmit-side frame controller for the SWIPT duty-cycle modulator.
- Accepts one data word from a requester over a valid/ready handshake.
- Serializes it as a timed frame: preamble, data (MSB first), optional parity, then guard interval.
- Drives the duty-adjust datapath's mode/control inputs (`program`, `write`, `read`, `data`) bit by bit, and releases the datapath to nominal duty whenever no frame is active or the link is down.

## Interface

Parameters:
- `DATA_W`, default 8: payload bits per frame.
- `BIT_CYCLES`, default 1000: clock cycles each symbol is held. Must be ≥2.
- `PREAMBLE_BITS`, default 4: preamble length. Must be ≥1. Pattern is 1,0,1,0,…
- `GUARD_CYCLES`, default 2000: idle cycles after the last symbol. Must be ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `swipt_alive`  in  1  link-up indication; low aborts or blocks frames.
- `req_valid`  in  1  requester has a word.
- `req_data`  in  DATA_W  word to send; sampled on accept.
- `req_ready`  out  1  combinational: state IDLE and `swipt_alive`=1.
- `program`  out  2  datapath mode.
- `write`  out  1  datapath write enable.
- `read`  out  1  datapath read enable. Always 0.
- `data`  out  1  current symbol to datapath.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at frame completion.
- `aborted`  out  1  one-cycle pulse when a frame is killed by `swipt_alive` low.

## Operation

States: IDLE, PREAMBLE, DATA, PARITY (present only with the macro), GUARD.

Idle outputs, held in IDLE and GUARD:
- `program`=2'b00, `write`=0, `read`=0, `data`=0.

Active outputs, held in PREAMBLE, DATA and PARITY:
- `program`=2'b11, `write`=1, `read`=0, `data`=current symbol.

State behaviour:
- IDLE:
  - Accept when `req_valid && req_ready`: latch `req_data` into the shift register.
  - Load the bit timer with `BIT_CYCLES-1` and the symbol counter with `PREAMBLE_BITS-1`.
  - Go to PREAMBLE.
- PREAMBLE:
  - Symbol i = 1 for even i, 0 for odd i.
  - When the bit timer reaches 0 on the last preamble symbol, go to DATA with symbol counter `DATA_W-1`.
- DATA:
  - `data` = shift-register MSB.
  - Shift left by one at each bit-timer expiry.
  - After the last bit, go to PARITY if compiled in, else GUARD.
- PARITY:
  - One symbol, held `BIT_CYCLES` cycles. Value per Configuration.
  - Then go to GUARD.
- GUARD:
  - Timer loaded with `GUARD_CYCLES-1`.
  - On expiry: go to IDLE and pulse `done`.

Bit timer:
- Down-counter, width `$clog2(max(BIT_CYCLES,GUARD_CYCLES))`.
- Reloads on expiry and never wraps.

Abort:
- Any non-IDLE state with `swipt_alive`=0 at a rising edge goes to IDLE on that edge.
- On that edge: idle outputs, `aborted`=1 for one cycle, `done` not asserted.
- The word is discarded; there is no retry.

Simultaneous events:
- Abort takes priority over a timer expiry, so a GUARD abort pulses `aborted`, not `done`.
- `req_valid` while busy: not accepted, no effect.
- `req_data` changes after accept have no effect.

## Timing

- All outputs except `req_ready` are registered.
- Accept at rising edge k:
  - First preamble symbol with `write`=1 is visible from edge k.
  - Each symbol is held exactly `BIT_CYCLES` cycles.
- With N = `PREAMBLE_BITS` + `DATA_W` (+1 if parity):
  - Active outputs from edge k to edge k+N·`BIT_CYCLES`.
  - Idle outputs from edge k+N·`BIT_CYCLES`.
  - `done` and IDLE from edge k+N·`BIT_CYCLES`+`GUARD_CYCLES`.
- `req_ready` rises in the same cycle `done` is high. Back-to-back accept occurs at that edge, giving zero-gap sequencing after guard.
- Reset (async):
  - State IDLE, idle outputs, `busy`=0, `done`=0, `aborted`=0, counters 0.
  - `req_ready` follows `swipt_alive` once reset is released.
  - Reset mid-frame forces idle outputs immediately, with no clock edge needed.

## Configuration

- `SWIPT_SEQ_PARITY_EN` defined:
  - PARITY state compiled in.
  - One even-parity symbol after the data: XOR of all `DATA_W` bits.
- Undefined:
  - No PARITY state; DATA goes directly to GUARD.
  - Frame is one symbol shorter.

## Test plan

All scenarios use `DATA_W`=8, `BIT_CYCLES`=4, `PREAMBLE_BITS`=4, `GUARD_CYCLES`=6.

- **Reset:** assert `rst` with `swipt_alive`=1 → `program`=00, `write`=0, `data`=0, `busy`=0. After release, `req_ready`=1.
- **Parity frame:** with parity enabled, accept 0xA5 at edge 0.
  - `data` symbols 1,0,1,0 | 1,0,1,0,0,1,0,1 | 0, each 4 cycles.
  - `write`=1 for 52 cycles, then 0.
  - `done` pulse at edge 58.
- **No-parity frame:** parity disabled, 0xA5 → 12 symbols, `write` drops at edge 48, `done` at edge 54.
- **Abort:** drop `swipt_alive` at cycle 20 of a frame → next edge gives `program`=00, `write`=0, `aborted`=1 for one cycle. No `done`; `req_ready`=0 until `swipt_alive` returns.
- **Back-to-back:** hold `req_valid`=1 with 0x3C, then 0xFF → second word accepted in the `done` cycle. Its first preamble symbol starts on that edge; there are no lost cycles.
- **Async reset:** assert `rst` mid-DATA between clock edges → outputs idle immediately. The frame is lost with no `done`/`aborted`.
